// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared algorithm encodings, default geometry, address widths and scaler FSM states
package zoom_pkg;

    localparam logic [1:0] ALG_NN = 2'd0;
    localparam logic [1:0] ALG_PR = 2'd1;
    localparam logic [1:0] ALG_DC = 2'd2;
    localparam logic [1:0] ALG_BA = 2'd3;

    localparam int SRC_W_DEF = 160;
    localparam int SRC_H_DEF = 120;
    localparam int PIX_W_DEF = 8;

    localparam int SRC_AW = 15;
    localparam int DST_AW = 17;
    localparam int XW     = 9;
    localparam int YW     = 8;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        WR,
        BA_R0,
        BA_R1,
        BA_R2,
        BA_R3,
        BA_WR,
        PR_W0,
        PR_W1,
        PR_W2,
        PR_W3,
        FIN
    } zoom_state_t;

endpackage

// File: rtl/zoom_raster_counter.sv
// rtl/zoom_raster_counter.sv - x/y raster counter with runtime size and incremental row base (y*width)
module zoom_raster_counter
    import zoom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [XW-1:0]     width,
    input  logic [YW-1:0]     height,
    output logic [XW-1:0]     x,
    output logic              y_odd,
    output logic [DST_AW-1:0] row_base,
    output logic              last
);

    logic [YW-1:0] y;
    logic          x_end;
    logic          y_end;

    assign x_end = (x == width - 1'b1);
    assign y_end = (y == height - 1'b1);
    assign last  = x_end && y_end;
    assign y_odd = y[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (clear) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (step) begin
            if (x_end) begin
                x <= '0;
                if (y_end) begin
                    y        <= '0;
                    row_base <= '0;
                end else begin
                    y        <= y + 1'b1;
                    row_base <= row_base + DST_AW'(width);
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zoom_scaler_engine.sv
// rtl/zoom_scaler_engine.sv - one-frame 2x up/down scaler (NN, PR, DC, BA) with memory strobes
// Optional: ZOOM_SCALER_BA_ROUND_EN selects round-half-up for the BA average instead of truncation.
module zoom_scaler_engine
    import zoom_pkg::*;
#(
    parameter int SRC_W = SRC_W_DEF,
    parameter int SRC_H = SRC_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        ALGORITHM,
    output logic              SRC_RD_EN,
    output logic [SRC_AW-1:0] SRC_ADDR,
    input  logic [PIX_W-1:0]  SRC_DATA,
    output logic              DST_WR_EN,
    output logic [DST_AW-1:0] DST_ADDR,
    output logic [PIX_W-1:0]  DST_DATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [XW-1:0]     UP_W   = XW'(2 * SRC_W);
    localparam logic [XW-1:0]     DN_W   = XW'(SRC_W / 2);
    localparam logic [XW-1:0]     SRC_WX = XW'(SRC_W);
    localparam logic [YW-1:0]     UP_H   = YW'(2 * SRC_H);
    localparam logic [YW-1:0]     DN_H   = YW'(SRC_H / 2);
    localparam logic [YW-1:0]     SRC_HY = YW'(SRC_H);
    localparam logic [DST_AW-1:0] UP_W_A = DST_AW'(2 * SRC_W);
    localparam logic [DST_AW-1:0] SRC_WA = DST_AW'(SRC_W);

    zoom_state_t state, nxt;
    logic [1:0]        algo_q;
    logic [PIX_W-1:0]  hold_q;
    logic [PIX_W+1:0]  acc_q;
    logic [SRC_AW-1:0] src_addr_q;
    logic [DST_AW-1:0] dst_addr_q;
    logic [PIX_W-1:0]  dst_data_q;

    logic [XW-1:0]     cnt_w, x;
    logic [YW-1:0]     cnt_h;
    logic              y_odd, last, step, accept;
    logic [DST_AW-1:0] row_base, quad_base, x_a, x2, nn_src;
    logic              rd_en, wr_en;
    logic [SRC_AW-1:0] src_c;
    logic [DST_AW-1:0] dst_c;
    logic [PIX_W-1:0]  data_c, ba_pix;
    logic [PIX_W+1:0]  ba_sum;

    zoom_raster_counter u_raster (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (accept),
        .step     (step),
        .width    (cnt_w),
        .height   (cnt_h),
        .x        (x),
        .y_odd    (y_odd),
        .row_base (row_base),
        .last     (last)
    );

    // NN and DC/BA iterate the destination, PR iterates the source.
    always_comb begin
        cnt_w = DN_W;
        cnt_h = DN_H;
        case (algo_q)
            ALG_NN: begin cnt_w = UP_W;   cnt_h = UP_H;   end
            ALG_PR: begin cnt_w = SRC_WX; cnt_h = SRC_HY; end
            default: ;
        endcase
    end

    // row_base<<2 is the 2y row of the other-resolution buffer; NN source row drops y's LSB first.
    assign x_a       = DST_AW'(x);
    assign x2        = x_a << 1;
    assign quad_base = row_base << 2;
    assign nn_src    = ((row_base - (y_odd ? UP_W_A : '0)) >> 2) + (x_a >> 1);

    assign ba_sum = acc_q + {2'b00, SRC_DATA};
`ifdef ZOOM_SCALER_BA_ROUND_EN
    assign ba_pix = PIX_W'((ba_sum + {{PIX_W{1'b0}}, 2'b10}) >> 2);
`else
    assign ba_pix = PIX_W'(ba_sum >> 2);
`endif

    always_comb begin
        nxt    = state;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        src_c  = '0;
        dst_c  = '0;
        data_c = '0;
        step   = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE: if (START) begin
                accept = 1'b1;
                nxt    = (ALGORITHM == ALG_BA) ? BA_R0 : RD;
            end
            RD: begin
                rd_en = 1'b1;
                case (algo_q)
                    ALG_NN:  src_c = SRC_AW'(nn_src);
                    ALG_PR:  src_c = SRC_AW'(row_base + x_a);
                    default: src_c = SRC_AW'(quad_base + x2);
                endcase
                nxt = (algo_q == ALG_PR) ? PR_W0 : WR;
            end
            WR: begin
                wr_en  = 1'b1;
                dst_c  = row_base + x_a;
                data_c = SRC_DATA;
                step   = 1'b1;
                nxt    = last ? FIN : RD;
            end
            BA_R0: begin rd_en = 1'b1; src_c = SRC_AW'(quad_base + x2);                 nxt = BA_R1; end
            BA_R1: begin rd_en = 1'b1; src_c = SRC_AW'(quad_base + x2 + 1'b1);          nxt = BA_R2; end
            BA_R2: begin rd_en = 1'b1; src_c = SRC_AW'(quad_base + x2 + SRC_WA);        nxt = BA_R3; end
            BA_R3: begin rd_en = 1'b1; src_c = SRC_AW'(quad_base + x2 + SRC_WA + 1'b1); nxt = BA_WR; end
            BA_WR: begin
                wr_en  = 1'b1;
                dst_c  = row_base + x_a;
                data_c = ba_pix;
                step   = 1'b1;
                nxt    = last ? FIN : BA_R0;
            end
            PR_W0: begin wr_en = 1'b1; dst_c = quad_base + x2;        data_c = SRC_DATA; nxt = PR_W1; end
            PR_W1: begin wr_en = 1'b1; dst_c = quad_base + x2 + 1'b1; data_c = hold_q;   nxt = PR_W2; end
            PR_W2: begin wr_en = 1'b1; dst_c = quad_base + x2 + UP_W_A; data_c = hold_q; nxt = PR_W3; end
            PR_W3: begin
                wr_en  = 1'b1;
                dst_c  = quad_base + x2 + UP_W_A + 1'b1;
                data_c = hold_q;
                step   = 1'b1;
                nxt    = last ? FIN : RD;
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            algo_q     <= ALG_NN;
            hold_q     <= '0;
            acc_q      <= '0;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
        end else begin
            if (accept) algo_q <= ALGORITHM;
            if (state == PR_W0) hold_q <= SRC_DATA;
            case (state)
                BA_R0:               acc_q <= '0;
                BA_R1, BA_R2, BA_R3: acc_q <= ba_sum;
                default: ;
            endcase
            if (rd_en) src_addr_q <= src_c;
            if (wr_en) begin
                dst_addr_q <= dst_c;
                dst_data_q <= data_c;
            end
        end
    end

    assign SRC_RD_EN = rd_en;
    assign SRC_ADDR  = rd_en ? src_c : src_addr_q;
    assign DST_WR_EN = wr_en;
    assign DST_ADDR  = wr_en ? dst_c : dst_addr_q;
    assign DST_DATA  = wr_en ? data_c : dst_data_q;
    assign BUSY      = (state != IDLE) && (state != FIN);
    assign DONE      = (state == FIN);

endmodule

// File: doc/zoom_scaler_engine.md
Name: zoom_scaler_engine

Overview:
- Datapath stage directly downstream of the zoom controller.
- Consumes the 2-bit ALGORITHM selection and, on a START pulse, performs one complete frame scale from the 160x120 8-bit source buffer into the destination frame buffer.
- Algorithms:
  - NN (nearest neighbour, 2x up)
  - PR (pixel replication, 2x up)
  - DC (decimation, 2x down)
  - BA (2x2 block average, 2x down)
- Produces memory read/write strobes plus BUSY/DONE status for the display path.

Parameters:
SRC_W, 160, source image width in pixels
SRC_H, 120, source image height in pixels
PIX_W, 8, pixel width in bits

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
START  input  1  one-cycle request to scale one frame
ALGORITHM  input  2  0=NN, 1=PR, 2=DC, 3=BA; sampled only on an accepted START
SRC_RD_EN  output  1  source read strobe
SRC_ADDR  output  15  source address = y*SRC_W + x
SRC_DATA  input  PIX_W  read data, valid exactly 1 cycle after SRC_RD_EN
DST_WR_EN  output  1  destination write strobe
DST_ADDR  output  17  destination address = y*DST_W + x
DST_DATA  output  PIX_W  write data
BUSY  output  1  high while a frame is in progress
DONE  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, active-high): FSM to IDLE; all outputs 0; counters and accumulator cleared. Reset mid-frame aborts the frame: no DONE, no further writes.
- Destination width DST_W: 2*SRC_W for NN/PR, SRC_W/2 for DC/BA. DST_H follows the same rule. Both are derived from the latched algorithm.
- START handling:
  - Accepted only in IDLE. ALGO_Q is latched from ALGORITHM at acceptance.
  - START while BUSY is ignored. ALGORITHM changes during a frame are ignored.
- START accepted at cycle t: BUSY=1 from t+1, first SRC_RD_EN at t+1.
- FSM states: IDLE, RD, WR, BA_R0..BA_R3, BA_WR, PR_W0..PR_W3, FIN.
- NN: raster over destination (x,y).
  - RD: SRC_ADDR = (y>>1)*SRC_W + (x>>1).
  - WR: DST_DATA = SRC_DATA.
  - 2 cycles per pixel; 76800 writes.
- DC: raster over destination.
  - RD: SRC_ADDR = (2y)*SRC_W + 2x.
  - WR: as NN.
  - 2 cycles per pixel; 4800 writes.
- PR: raster over source (x,y).
  - RD: one read. PR_W0 captures SRC_DATA into a hold register.
  - PR_W0..W3 write the hold value to (2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1), in that order.
  - 5 cycles per source pixel.
- BA: raster over destination.
  - BA_R0..R3 read (2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1).
  - A 10-bit accumulator adds each SRC_DATA one cycle after its read.
  - BA_WR adds the 4th sample and writes sum>>2 (rounding per optional feature).
  - 5 cycles per pixel.
- Raster order: x increments first; x wraps 0 at width-1 and y increments; frame ends after (width-1,height-1).
- FIN: after the last write, DONE=1 and BUSY=0 in the same cycle, for 1 cycle. Return to IDLE.
- A START in the DONE cycle is ignored. START is accepted from the following cycle.
- SRC_RD_EN and DST_WR_EN are never high in the same cycle.
- Address outputs hold their last value when the strobe is low.

Optional Feature:
- Macro: ZOOM_SCALER_BA_ROUND_EN.
- Defined: BA output = (sum+2)>>2 (round half up).
- Undefined: BA output = sum>>2 (truncate).
- NN, PR and DC are unaffected.

Decomposition:
- Shared package zoom_pkg:
  - algorithm encodings ALG_NN/ALG_PR/ALG_DC/ALG_BA (also used by the zoom controller)
  - SRC_W/SRC_H defaults
  - address widths 15/17
- Natural sub-module: zoom_raster_counter, an x/y counter with runtime width/height, step enable and last-pixel flag. It also maintains an incremental row-base address so no multiplier is needed. Instanced once.

Test Plan:
- Source model: mem[a] = a[7:0] with a 1-cycle read model.
- NN, ALGORITHM=0, START:
  - 76800 writes.
  - DST_ADDR 321 gets src[0]=0x00; DST_ADDR 642 gets src[161]=0xA1.
  - DONE at 153600 cycles + FSM overhead.
- PR, ALGORITHM=1:
  - First 4 writes to DST_ADDR 0,1,320,321, all data 0x00.
  - Next 4 writes to 2,3,322,323 with data 0x01.
  - 76800 writes total.
- DC, ALGORITHM=2:
  - 4800 writes.
  - DST_ADDR 1 = src[2]=0x02; DST_ADDR 80 = src[320]=0x40.
- BA, ALGORITHM=3, src[0,1,160,161] preloaded with 1,2,3,4:
  - DST_ADDR 0 = 3 with ZOOM_SCALER_BA_ROUND_EN, 2 without.
  - 4800 writes.
- Reset mid-frame (BA, assert RESET after 100 writes):
  - All outputs 0 immediately, no DONE.
  - Next START restarts at SRC_ADDR 0 / DST_ADDR 0.
- Ignored inputs (START and ALGORITHM=2 applied mid-NN frame):
  - Frame completes as NN with 76800 writes.
  - DONE pulses for exactly 1 cycle.
